// File: rtl/arm32_fetch_unit.sv
// ---------------------------------------------------------------------------
// arm32_fetch_unit
//
// Instruction-fetch stage sitting in front of arm32_decoder. It owns the
// program counter, issues word reads to a synchronous instruction RAM with
// a one-cycle read latency, and hands {instruction, PC} to decode through a
// valid/ready handshake. A one-entry skid buffer absorbs the in-flight read
// when decode stalls, so no instruction is lost or repeated. A taken branch
// from execute flushes everything in flight and restarts fetch at the target.
//
// Ports:
//   clk          : single clock, all state changes on the rising edge
//   i_reset_n    : asynchronous active-low reset
//   i_ready      : decoder accepts o_ins/o_pc this cycle
//   i_br         : branch taken, redirect fetch
//   i_br_addr    : branch target byte address (bits [1:0] ignored)
//   o_imem_en    : read request to the instruction RAM this cycle
//   o_imem_addr  : word address of the request
//   i_imem_data  : RAM read data, valid the cycle after a request
//   o_valid      : o_ins/o_pc hold a valid instruction
//   o_ins        : instruction word
//   o_pc         : byte address of o_ins
// ---------------------------------------------------------------------------
module arm32_fetch_unit #(
  parameter int          N        = 32,
  parameter int          ADDR_W   = 10,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              i_reset_n,
  input  logic              i_ready,
  input  logic              i_br,
  input  logic [N-1:0]      i_br_addr,
  output logic              o_imem_en,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic [N-1:0]      i_imem_data,
  output logic              o_valid,
  output logic [N-1:0]      o_ins,
  output logic [N-1:0]      o_pc
);

  logic [N-1:0] r_fetchPc;
  logic         r_reqVld;
  logic [N-1:0] r_reqPc;
  logic         r_skidVld;
  logic [N-1:0] r_skidIns;
  logic [N-1:0] r_skidPc;

  logic         w_issue;
  logic [N-1:0] w_brPc;
  logic [N-1:0] w_issuePc;
  logic         w_outFree;

  // Issue decision. A new read is only started when its data is guaranteed
  // a home next cycle: the skid must be empty, and if the output is stalled
  // with a read already in flight, that read will take the skid slot. A
  // branch always issues because it discards everything already held.
  assign w_issue   = i_br | (~r_skidVld & ~(o_valid & ~i_ready & r_reqVld));
  assign w_brPc    = i_br_addr & ~N'(3);
  assign w_issuePc = i_br ? w_brPc : r_fetchPc;
  assign w_outFree = ~o_valid | i_ready;

  // The RAM index simply truncates the byte address, so sequential fetch
  // wraps around the RAM while the architectural PC keeps counting.
  assign o_imem_en   = i_reset_n & w_issue;
  assign o_imem_addr = w_issuePc[ADDR_W+1:2];

  // Request tracking: remember which PC the outstanding read belongs to and
  // advance the sequential fetch pointer past it.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_reqVld  <= 1'b0;
      r_reqPc   <= '0;
      r_fetchPc <= N'(RESET_PC);
    end else begin
      r_reqVld <= w_issue;
      if (w_issue) begin
        r_reqPc   <= w_issuePc;
        r_fetchPc <= w_issuePc + N'(4);
      end
    end
  end

  // Output register and skid buffer. A branch wins over everything and
  // drops the arriving read data. Otherwise the skid entry is always older
  // than an arrival, so it is moved to the output first to keep PC order.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_valid   <= 1'b0;
      o_ins     <= '0;
      o_pc      <= '0;
      r_skidVld <= 1'b0;
      r_skidIns <= '0;
      r_skidPc  <= '0;
    end else if (i_br) begin
      o_valid   <= 1'b0;
      r_skidVld <= 1'b0;
    end else if (r_reqVld) begin
      if (w_outFree) begin
        o_valid <= 1'b1;
        if (r_skidVld) begin
          o_ins     <= r_skidIns;
          o_pc      <= r_skidPc;
          r_skidIns <= i_imem_data;
          r_skidPc  <= r_reqPc;
        end else begin
          o_ins <= i_imem_data;
          o_pc  <= r_reqPc;
        end
      end else begin
        r_skidVld <= 1'b1;
        r_skidIns <= i_imem_data;
        r_skidPc  <= r_reqPc;
      end
    end else if (w_outFree) begin
      if (r_skidVld) begin
        o_valid   <= 1'b1;
        o_ins     <= r_skidIns;
        o_pc      <= r_skidPc;
        r_skidVld <= 1'b0;
      end else begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arm32_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_arm32_fetch_unit
//
// Directed bench for arm32_fetch_unit. A behavioural synchronous RAM with
// one-cycle latency holds mem[w] = 0xE0000000 + w. Each directed step
// advances one rising edge, waits 1 time unit, then compares outputs
// against hand-derived values.
// ---------------------------------------------------------------------------
module tb_arm32_fetch_unit;

  logic        clk;
  logic        i_reset_n;
  logic        i_ready;
  logic        i_br;
  logic [31:0] i_br_addr;
  logic        o_imem_en;
  logic [9:0]  o_imem_addr;
  logic [31:0] i_imem_data;
  logic        o_valid;
  logic [31:0] o_ins;
  logic [31:0] o_pc;

  int total;
  int bad;

  logic [31:0] mem [0:1023];

  arm32_fetch_unit #(
    .N(32),
    .ADDR_W(10),
    .RESET_PC(0)
  ) dut (
    .clk(clk),
    .i_reset_n(i_reset_n),
    .i_ready(i_ready),
    .i_br(i_br),
    .i_br_addr(i_br_addr),
    .o_imem_en(o_imem_en),
    .o_imem_addr(o_imem_addr),
    .i_imem_data(i_imem_data),
    .o_valid(o_valid),
    .o_ins(o_ins),
    .o_pc(o_pc)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction RAM: data for a request appears after the edge
  // that samples the request.
  always @(posedge clk) begin
    if (o_imem_en) i_imem_data <= mem[o_imem_addr];
  end

  // Drive all DUT inputs in one place.
  task automatic applyStimulus(input logic rstN, input logic rdy,
                               input logic br, input logic [31:0] brAddr);
    i_reset_n = rstN;
    i_ready   = rdy;
    i_br      = br;
    i_br_addr = brAddr;
  endtask

  // Compare one observed value with its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check a presented instruction: valid, PC and word.
  task automatic checkBeat(input string tag, input logic [31:0] pc,
                           input logic [31:0] ins);
    checkOutput({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
    checkOutput({tag, "_pc"}, o_pc, pc);
    checkOutput({tag, "_ins"}, o_ins, ins);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    i_imem_data = '0;
    for (int w = 0; w < 1024; w++) mem[w] = 32'hE000_0000 + 32'(w);

    // ---------------- reset state ----------------
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    #2;
    step();
    checkOutput("rst_valid", {31'd0, o_valid}, 32'd0);
    checkOutput("rst_ins", o_ins, 32'd0);
    checkOutput("rst_pc", o_pc, 32'd0);
    checkOutput("rst_en", {31'd0, o_imem_en}, 32'd0);

    // ---------------- streaming after reset release ----------------
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    #1;
    checkOutput("rel_en", {31'd0, o_imem_en}, 32'd1);
    checkOutput("rel_addr", {22'd0, o_imem_addr}, 32'd0);
    step();                                       // edge 1
    checkOutput("e1_valid", {31'd0, o_valid}, 32'd0);
    checkOutput("e1_addr", {22'd0, o_imem_addr}, 32'd1);
    step();                                       // edge 2
    checkBeat("s0", 32'd0, 32'hE000_0000);
    step();
    checkBeat("s4", 32'd4, 32'hE000_0001);
    step();                                       // o_pc = 8
    checkBeat("s8", 32'd8, 32'hE000_0002);

    // ---------------- stall 3 cycles at PC 8 ----------------
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    checkOutput("stall_en0", {31'd0, o_imem_en}, 32'd0);
    step();                                       // PC 12 goes to skid
    checkBeat("hold1", 32'd8, 32'hE000_0002);
    checkOutput("stall_en1", {31'd0, o_imem_en}, 32'd0);
    step();
    checkBeat("hold2", 32'd8, 32'hE000_0002);
    step();
    checkBeat("hold3", 32'd8, 32'hE000_0002);
    checkOutput("stall_en3", {31'd0, o_imem_en}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    step();                                       // skid -> output
    checkBeat("rs12", 32'd12, 32'hE000_0003);
    checkOutput("rs_en", {31'd0, o_imem_en}, 32'd1);
    checkOutput("rs_addr", {22'd0, o_imem_addr}, 32'd4);
    step();                                       // refill bubble
    checkOutput("rs_bubble", {31'd0, o_valid}, 32'd0);
    step();
    checkBeat("rs16", 32'd16, 32'hE000_0004);
    step();
    checkBeat("rs20", 32'd20, 32'hE000_0005);

    // ---------------- branch with PC 0x0C in flight ----------------
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    #1;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    step();
    step();
    checkBeat("b0", 32'd0, 32'hE000_0000);
    step();
    step();
    checkBeat("b8", 32'd8, 32'hE000_0002);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h40);
    #1;
    checkOutput("br_en", {31'd0, o_imem_en}, 32'd1);
    checkOutput("br_addr", {22'd0, o_imem_addr}, 32'h10);
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("br_flush", {31'd0, o_valid}, 32'd0);
    step();
    checkBeat("br40", 32'h40, 32'hE000_0010);
    step();
    checkBeat("br44", 32'h44, 32'hE000_0011);

    // ---------------- branch while stalled with skid full ----------------
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    step();                                       // 0x48 lands in skid
    checkBeat("sk44", 32'h44, 32'hE000_0011);
    checkOutput("sk_en", {31'd0, o_imem_en}, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h80);
    #1;
    checkOutput("sk_br_en", {31'd0, o_imem_en}, 32'd1);
    checkOutput("sk_br_addr", {22'd0, o_imem_addr}, 32'h20);
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("sk_flush", {31'd0, o_valid}, 32'd0);
    step();
    checkBeat("sk80", 32'h80, 32'hE000_0020);
    step();
    checkBeat("sk84", 32'h84, 32'hE000_0021);

    // ---------------- unaligned branch target ----------------
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h43);
    #1;
    checkOutput("ua_addr", {22'd0, o_imem_addr}, 32'h10);
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    step();
    checkBeat("ua40", 32'h40, 32'hE000_0010);
    step();
    checkBeat("ua44", 32'h44, 32'hE000_0011);

    // ---------------- RAM address wrap ----------------
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hFF8);
    #1;
    checkOutput("wr_addr0", {22'd0, o_imem_addr}, 32'h3FE);
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    #1;
    checkOutput("wr_addr1", {22'd0, o_imem_addr}, 32'h3FF);
    step();
    checkBeat("wrFF8", 32'hFF8, 32'hE000_03FE);
    checkOutput("wr_addr2", {22'd0, o_imem_addr}, 32'h000);
    step();
    checkBeat("wrFFC", 32'hFFC, 32'hE000_03FF);
    step();
    checkBeat("wr1000", 32'h1000, 32'hE000_0000);

    // ---------------- asynchronous reset pulse mid-stream ----------------
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    #1;
    checkOutput("ar_valid", {31'd0, o_valid}, 32'd0);
    checkOutput("ar_pc", o_pc, 32'd0);
    checkOutput("ar_en", {31'd0, o_imem_en}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    #1;
    checkOutput("ar_addr", {22'd0, o_imem_addr}, 32'd0);
    step();
    checkOutput("ar_e1", {31'd0, o_valid}, 32'd0);
    step();
    checkBeat("ar0", 32'd0, 32'hE000_0000);
    step();
    checkBeat("ar4", 32'd4, 32'hE000_0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
